// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 capture slice.
package ov7670_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StSync, StActive} state_e;

  localparam int unsigned DefaultHActive = 320;
  localparam int unsigned DefaultVActive = 240;
  localparam int unsigned DefaultAddrW   = 17;

  function automatic bit bpp_is_legal(input int unsigned bpp);
    return (bpp == 1) || (bpp == 2);
  endfunction

endpackage

// File: rtl/ov7670_pixel_assembler.sv
// Sensor byte assembly: byte phase tracking, href edge detect, pixel-valid pulse and pixel MSBs.
module ov7670_pixel_assembler
  import ov7670_pkg::*;
#(
  parameter int unsigned DOUT_W          = 2,
  parameter int unsigned BYTES_PER_PIXEL = 1
) (
  input  logic              pclk_12,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              pix_valid,
  output logic [DOUT_W-1:0] pix_data,
  output logic              line_end
);

  localparam bit TwoByte = (BYTES_PER_PIXEL == 2);

  logic              href_q;
  logic              phase_q;
  logic              got_byte_q;
  logic [DOUT_W-1:0] first_q;
  logic              take;
  logic              href_fall;
  logic              unused_d;

  assign unused_d  = ^d;
  assign take      = enable && href;
  assign href_fall = href_q && !href;
  assign pix_valid = take && (!TwoByte || phase_q);
  assign pix_data  = TwoByte ? first_q : d[7 -: DOUT_W];
  // Row advance only for lines that actually delivered data.
  assign line_end  = enable && href_fall && got_byte_q;

  always_ff @(posedge pclk_12) begin
    if (!reset_n) begin
      href_q     <= 1'b0;
      phase_q    <= 1'b0;
      got_byte_q <= 1'b0;
      first_q    <= '0;
    end else begin
      href_q <= href;
      if (!enable || href_fall) begin
        phase_q    <= 1'b0;
        got_byte_q <= 1'b0;
      end else if (take) begin
        got_byte_q <= 1'b1;
        phase_q    <= TwoByte && !phase_q;
        if (!phase_q) first_q <= d[7 -: DOUT_W];
      end
    end
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture front-end producing framebuffer write strobes with row-major addresses.
// Optional OV7670_CAPTURE_TEST_PATTERN_EN adds a test_pattern input that replaces pixel data.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DefaultHActive,
  parameter int unsigned V_ACTIVE        = DefaultVActive,
  parameter int unsigned ADDR_W          = DefaultAddrW,
  parameter int unsigned DOUT_W          = 2,
  parameter int unsigned BYTES_PER_PIXEL = 1
) (
  input  logic              pclk_12,
  input  logic              reset_n,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [DOUT_W-1:0] dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned   ColW  = 16;
  localparam logic [ColW-1:0]   HMax  = ColW'(H_ACTIVE);
  localparam logic [ColW-1:0]   VMax  = ColW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HStep = ADDR_W'(H_ACTIVE);

  if (!bpp_is_legal(BYTES_PER_PIXEL)) begin : gen_bpp_check
    $error("BYTES_PER_PIXEL must be 1 or 2");
  end
  if (DOUT_W < 1 || DOUT_W > 8) begin : gen_dout_check
    $error("DOUT_W must be in 1..8");
  end
  if ((64'd1 << ADDR_W) < 64'(H_ACTIVE) * 64'(V_ACTIVE)) begin : gen_addr_check
    $error("ADDR_W too small for H_ACTIVE*V_ACTIVE");
  end

  state_e            state_q;
  logic              busy_q, we_q, frame_done_q, overflow_q;
  logic [ADDR_W-1:0] addr_q, pix_addr_q, line_base_q;
  logic [DOUT_W-1:0] dout_q, pix_data, pix_val;
  logic [ColW-1:0]   col_q, row_q;
  logic              asm_en, pix_valid, line_end, enter_sync;

  assign asm_en     = (state_q == StActive) && !vsync;
  assign enter_sync = vsync && ((state_q == StArm) || ((state_q == StActive) && start));

  ov7670_pixel_assembler #(
    .DOUT_W          (DOUT_W),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
  ) u_assembler (
    .pclk_12   (pclk_12),
    .reset_n   (reset_n),
    .enable    (asm_en),
    .href      (href),
    .d         (d),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .line_end  (line_end)
  );

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  // 32-pixel-wide vertical bars keyed off the column being written.
  assign pix_val = test_pattern ? col_q[DOUT_W+4:5] : pix_data;
`else
  assign pix_val = pix_data;
`endif

  always_ff @(posedge pclk_12) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pix_addr_q   <= '0;
      line_base_q  <= '0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: if (start) state_q <= StArm;
        StArm:  if (vsync) state_q <= StSync;
        StSync: if (!vsync) state_q <= StActive;
        StActive: begin
          if (vsync) begin
            frame_done_q <= 1'b1;
            state_q      <= start ? StSync : StIdle;
            busy_q       <= start;
          end else if (pix_valid) begin
            if (col_q < HMax && row_q < VMax) begin
              we_q       <= 1'b1;
              addr_q     <= pix_addr_q;
              dout_q     <= pix_val;
              col_q      <= col_q + ColW'(1);
              pix_addr_q <= pix_addr_q + ADDR_W'(1);
            end else begin
              overflow_q <= 1'b1;
            end
          end else if (line_end) begin
            col_q <= '0;
            // Row saturates at V_ACTIVE so the address never wraps back to 0.
            if (row_q < VMax) begin
              row_q       <= row_q + ColW'(1);
              line_base_q <= line_base_q + HStep;
              pix_addr_q  <= line_base_q + HStep;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (enter_sync) begin
        busy_q      <= 1'b1;
        overflow_q  <= 1'b0;
        col_q       <= '0;
        row_q       <= '0;
        pix_addr_q  <= '0;
        line_base_q <= '0;
      end
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench: one byte stream drives a 1-byte/pixel and a 2-byte/pixel capture instance.
module tb_ov7670_pixel_capture;

  localparam int unsigned H  = 320;
  localparam int unsigned V1 = 6;
  localparam int unsigned V2 = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] v;
  } wr_t;
  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic [7:0] d = 8'h00;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic test_pattern = 1'b0;
`endif
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] dout1, dout2;
  logic we1, we2, busy1, busy2, fd1, fd2, ov1, ov2;

  always #5 clk = ~clk;

  ov7670_pixel_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V1), .ADDR_W(AW), .DOUT_W(DW), .BYTES_PER_PIXEL(1)
  ) dut1 (
    .pclk_12(clk), .reset_n(reset_n), .start(start), .vsync(vsync), .href(href), .d(d),
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .addr(addr1), .dout(dout1), .we(we1), .busy(busy1), .frame_done(fd1), .overflow(ov1)
  );

  ov7670_pixel_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V2), .ADDR_W(AW), .DOUT_W(DW), .BYTES_PER_PIXEL(2)
  ) dut2 (
    .pclk_12(clk), .reset_n(reset_n), .start(start), .vsync(vsync), .href(href), .d(d),
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .addr(addr2), .dout(dout2), .we(we2), .busy(busy2), .frame_done(fd2), .overflow(ov2)
  );

  int  checks = 0;
  int  errors = 0;
  wr_t q1[$], q2[$];
  wr_t e1, e2;
  int  wr1 = 0, wr2 = 0, wr1_base = 0, wr2_base = 0, n1 = 0, n2 = 0;
  int  fd_obs1 = 0, fd_obs2 = 0, fd_exp = 0;
  int  row = 0;
  bit  cap = 1'b0;
  bit  ovf1_exp = 1'b0, ovf2_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we1) begin
      wr1++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr1_unexpected: got write addr %0d expected no write", addr1);
      end else begin
        e1 = q1.pop_front();
        check("wr1_addr", 64'(addr1), 64'(e1.a));
        check("wr1_dout", 64'(dout1), 64'(e1.v));
      end
    end
    if (we2) begin
      wr2++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr2_unexpected: got write addr %0d expected no write", addr2);
      end else begin
        e2 = q2.pop_front();
        check("wr2_addr", 64'(addr2), 64'(e2.a));
        check("wr2_dout", 64'(dout2), 64'(e2.v));
      end
    end
    if (fd1) fd_obs1++;
    if (fd2) fd_obs2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: pixel p of line r lands at r*H+p when inside the frame, else it is an overflow.
  task automatic push_pix(input int which, input int pix, input logic [7:0] b);
    int unsigned vmax = (which == 1) ? V1 : V2;
    int unsigned val  = b >> (8 - DW);
    wr_t e;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    if (test_pattern) val = (pix / 32) % (1 << DW);
`endif
    if (row < vmax && pix < H) begin
      e.a = AW'(row * H + pix);
      e.v = DW'(val);
      if (which == 1) begin q1.push_back(e); n1++; end
      else begin q2.push_back(e); n2++; end
    end else if (which == 1) begin
      ovf1_exp = 1'b1;
    end else begin
      ovf2_exp = 1'b1;
    end
  endtask

  task automatic send_line(input bytes_t b);
    for (int i = 0; i < b.size(); i++) begin
      href = 1'b1;
      d    = b[i];
      if (cap) begin
        push_pix(1, i, b[i]);
        if (i % 2 == 1) push_pix(2, i / 2, b[i-1]);
      end
      tick();
    end
    href = 1'b0;
    d    = 8'($urandom);
    if (cap && b.size() > 0) row++;
    repeat (4) tick();
  endtask

  task automatic rand_lines(input int nlines, input int len);
    bytes_t b;
    for (int l = 0; l < nlines; l++) begin
      b = {};
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      send_line(b);
    end
  endtask

  task automatic vsync_pulse();
    check("ovf1_frame_end", 64'(ov1), 64'(ovf1_exp));
    check("ovf2_frame_end", 64'(ov2), 64'(ovf2_exp));
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("wr1_frame_count", 64'(wr1 - wr1_base), 64'(n1));
    check("wr2_frame_count", 64'(wr2 - wr2_base), 64'(n2));
    // href is high alongside the vsync edge; that byte must never be stored.
    vsync = 1'b1;
    href  = 1'b1;
    d     = 8'($urandom);
    tick();
    check("fd1_timing", 64'(fd1), 64'(cap));
    check("fd2_timing", 64'(fd2), 64'(cap));
    if (cap) fd_exp++;
    href = 1'b0;
    cap  = start;
    if (cap) begin
      row = 0; ovf1_exp = 1'b0; ovf2_exp = 1'b0;
    end
    n1 = 0; n2 = 0; wr1_base = wr1; wr2_base = wr2;
    repeat (2) tick();
    vsync = 1'b0;
    check("busy1", 64'(busy1), 64'(cap));
    check("busy2", 64'(busy2), 64'(cap));
    check("ovf1_after_sync", 64'(ov1), 64'(ovf1_exp));
    check("ovf2_after_sync", 64'(ov2), 64'(ovf2_exp));
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_addr1", 64'(addr1), 64'd0);
    check("rst_dout1", 64'(dout1), 64'd0);
    check("rst_we1", 64'(we1), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_fd1", 64'(fd1), 64'd0);
    check("rst_ovf1", 64'(ov1), 64'd0);
    check("rst_addr2", 64'(addr2), 64'd0);
    check("rst_dout2", 64'(dout2), 64'd0);
    check("rst_we2", 64'(we2), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    check("rst_fd2", 64'(fd2), 64'd0);
    check("rst_ovf2", 64'(ov2), 64'd0);
    reset_n  = 1'b1;
    cap      = 1'b0;
    ovf1_exp = 1'b0;
    ovf2_exp = 1'b0;
    tick();
  endtask

  initial begin
    bytes_t b;
    tick();
    apply_reset();

    // Reset while capturing with start held: the rest of that frame is ignored.
    start = 1'b1;
    repeat (3) tick();
    vsync_pulse();
    rand_lines(2, H);
    apply_reset();
    rand_lines(2, H);
    vsync_pulse();
    rand_lines(V1, H);

    // Drop start: current frame finished, next frame ignored, start raised mid-frame.
    start = 1'b0;
    vsync_pulse();
    rand_lines(2, H);
    start = 1'b1;
    rand_lines(2, H);
    vsync_pulse();
    rand_lines(V1, H);
    vsync_pulse();
    rand_lines(V1, H);
    vsync_pulse();

    // RGB565-style lines, odd byte count, and an over-long line.
    b = {};
    for (int i = 0; i < 2 * H; i++) b.push_back((i % 2 == 0) ? 8'hC0 : 8'h00);
    send_line(b);
    send_line(b);
    rand_lines(1, 2 * H + 1);
    rand_lines(1, H + 10);
    rand_lines(1, H);
    vsync_pulse();
    rand_lines(2, H + 10);

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    vsync_pulse();
    test_pattern = 1'b1;
    rand_lines(2, 2 * H);
    test_pattern = 1'b0;
`endif

    start = 1'b0;
    vsync_pulse();
    repeat (10) tick();
    check("fd1_total", 64'(fd_obs1), 64'(fd_exp));
    check("fd2_total", 64'(fd_obs2), 64'(fd_exp));
    check("q1_final_empty", 64'(q1.size()), 64'd0);
    check("q2_final_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ov7670_pixel_capture.md
# ov7670_pixel_capture

Parametrised OV7670 capture front-end: samples the sensor's `vsync`/`href`/`d` bus and produces framebuffer write strobes with a row-major pixel address. It supersedes the fixed 2-bit, single-byte capture block. Its additions are:
- configurable output depth, resolution and bytes per pixel;
- frame-aligned arming;
- explicit write enable;
- overflow detection.

It sits between the sensor pins and the block-RAM framebuffer, downstream of register configuration.

## Interface
Parameters:
- `H_ACTIVE`, 320: active pixels per line.
- `V_ACTIVE`, 240: active lines per frame.
- `ADDR_W`, 17: framebuffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- `DOUT_W`, 2: stored bits per pixel, 1..8.
- `BYTES_PER_PIXEL`, 1: sensor bytes per pixel, 1 (raw/YUV-Y) or 2 (RGB565).

Ports:
- `pclk_12` in 1: 12 MHz pixel clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: capture enable; level-sensitive.
- `vsync` in 1: sensor vertical sync, active high.
- `href` in 1: sensor line-valid.
- `d` in 8: sensor data byte.
- `addr` out ADDR_W: framebuffer write address.
- `dout` out DOUT_W: pixel data to write.
- `we` out 1: write strobe, one cycle per stored pixel.
- `busy` out 1: high in SYNC or ACTIVE.
- `frame_done` out 1: one-cycle pulse at the end of a captured frame.
- `overflow` out 1: sticky per frame; pixels were dropped.

## Operation
States:
- **IDLE**: waits for `start`=1, then goes to ARM.
- **ARM**: waits for `vsync`=1, then goes to SYNC. This guarantees whole frames only; a partial frame in progress is never captured.
- **SYNC**: waits for `vsync`=0, then goes to ACTIVE. On entry: row=col=0, byte phase=0, `overflow` cleared.
- **ACTIVE**: captures the frame.
  - Leaves on `vsync`=1: pulses `frame_done`, then goes to SYNC if `start`=1, else IDLE.
  - Deasserting `start` mid-frame does not abort; the current frame completes.

Byte assembly, in ACTIVE with `href`=1:
- BYTES_PER_PIXEL=1: every byte is a pixel; pixel value is `d[7:8-DOUT_W]`.
- BYTES_PER_PIXEL=2: the first byte is held; the pixel completes on the second byte; pixel value is the first byte's `[7:8-DOUT_W]` (MSBs of R in RGB565).
- `href` falling edge: byte phase resets to 0 and any half pixel is discarded. col resets to 0; row increments if the line held at least one byte.

Addressing:
- `addr` = row*H_ACTIVE + col, maintained incrementally (no multiplier).
- A completed pixel with col >= H_ACTIVE or row >= V_ACTIVE is not written and sets `overflow`.
- col and row saturate; they never wrap to address 0.

Outputs are registered. `dout` holds its last value when `we`=0.

## Timing
- Reset values: `addr`=0, `dout`=0, `we`=0, `busy`=0, `frame_done`=0, `overflow`=0, state IDLE. A reset mid-frame behaves identically and returns to IDLE.
- Latency: `we`/`addr`/`dout` are valid on the cycle after the edge that samples the completing byte.
- Max write rate:
  - BYTES_PER_PIXEL=1: one write per cycle.
  - BYTES_PER_PIXEL=2: one write every 2 cycles.
- First write of a frame has `addr`=0. In a full frame, the last write has `addr`=H_ACTIVE*V_ACTIVE-1.
- `frame_done` is asserted one cycle after the `vsync` rising edge is sampled in ACTIVE.
- `vsync`=1 together with `href`=1 in ACTIVE: vsync wins; the byte is ignored.

## Configuration
- `OV7670_CAPTURE_TEST_PATTERN_EN` defined:
  - Adds input port `test_pattern` (1 bit).
  - When `test_pattern`=1, every stored pixel has `dout` = col[DOUT_W+4:5], i.e. vertical bars 32 pixels wide. Timing, `we` and addressing are unchanged; `d` is ignored.
- Macro undefined: no `test_pattern` port; `dout` always comes from sensor data.

## Structure
- Package `ov7670_pkg`: state enum (IDLE, ARM, SYNC, ACTIVE), default resolution constants, and a function for the BYTES_PER_PIXEL legality check.
- Sub-module `ov7670_pixel_assembler`:
  - Covers the byte phase and `href` edge detect.
  - Outputs a pixel-valid pulse plus pixel MSBs.
  - The top-level block owns the FSM, counters and outputs.

## Test plan
- Reset held while `start`=1 mid-frame -> all outputs 0, state IDLE; after release, no writes occur until the next `vsync` pulse.
- `start` raised mid-frame, then two full 320x240 frames (BYTES_PER_PIXEL=1) -> the partial frame is ignored. Each captured frame gives exactly 76800 `we` pulses, `addr` runs 0..76799, and there is one `frame_done` per frame.
- BYTES_PER_PIXEL=2 with a line of 640 bytes alternating 0xC0, 0x00 -> 320 writes per line, all with `dout`=3.
- Line of 330 pixels -> 320 writes, `overflow`=1, last `addr` of line = row*320+319; `overflow` cleared after the next SYNC.
- Odd byte count (641) with BYTES_PER_PIXEL=2 -> 320 writes; the half pixel is discarded; the next line starts at col 0.
- With the macro defined and `test_pattern`=1 at DOUT_W=2 -> pixels 0..31 get `dout`=0, pixels 32..63 get `dout`=1, pixel 128 gets `dout`=0.
